// File: rtl/sdram_wb_master.sv
// Wishbone master for the SDRAM controller: a request FIFO feeds one classic Wishbone cycle at a time.
// Read data is returned in order on a valid/ready port. A watchdog aborts any cycle whose ack never arrives.
module sdram_wb_master #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [22:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_rdata,
  output logic [22:0]                   addr_o,
  output logic [31:0]                   dat_o,
  input  logic [31:0]                   dat_i,
  output logic                          we_o,
  output logic                          stb_o,
  output logic                          cyc_o,
  input  logic                          ack_i,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          timeout_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [22:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUS, ACKLOW, RSP} state_t;

  req_t             fifo_mem [FIFO_DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  state_t           state_q, state_d;
  logic             push, pop;
  logic             stb_d, we_d, timeout_d, rsp_valid_d, busy_d, req_ready_d;
  logic [22:0]      addr_d;
  logic [31:0]      dat_d, rdata_d;

  assign push = req_valid && req_ready;
  assign head = fifo_mem[rd_ptr];

  // FIFO storage; contents need no reset because the pointers and level are cleared
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    stb_d       = stb_o;
    we_d        = we_o;
    addr_d      = addr_o;
    dat_d       = dat_o;
    rdata_d     = rsp_rdata;
    rsp_valid_d = rsp_valid;
    timeout_d   = 1'b0;
    wdog_d      = wdog_q;
    unique case (state_q)
      IDLE: begin
        if (fifo_level_o != '0) begin
          pop     = 1'b1;
          addr_d  = head.addr;
          dat_d   = head.wdata;
          we_d    = head.we;
          stb_d   = 1'b1;
          wdog_d  = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // A late ack on the expiry cycle still wins over the watchdog
        if (ack_i) begin
          stb_d   = 1'b0;
          if (!we_o) rdata_d = dat_i;
          state_d = ACKLOW;
        end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          stb_d     = 1'b0;
          timeout_d = 1'b1;
          if (!we_o) rdata_d = ABORT_DATA;
          state_d   = ACKLOW;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ACKLOW: begin
        // The controller stretches ack; never launch again until it has fallen
        if (!ack_i) begin
          if (we_o) begin
            state_d = IDLE;
          end else begin
            rsp_valid_d = 1'b1;
            state_d     = RSP;
          end
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    count_d     = fifo_level_o + LVL_W'(push) - LVL_W'(pop);
    req_ready_d = (count_d != LVL_W'(FIFO_DEPTH));
    busy_d      = (state_d != IDLE) || (count_d != '0);
  end

  // State, pointers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level_o <= '0;
      wdog_q       <= '0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      addr_o       <= '0;
      dat_o        <= '0;
      we_o         <= 1'b0;
      stb_o        <= 1'b0;
      cyc_o        <= 1'b0;
      busy_o       <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level_o <= count_d;
      wdog_q       <= wdog_d;
      req_ready    <= req_ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rdata_d;
      addr_o       <= addr_d;
      dat_o        <= dat_d;
      we_o         <= we_d;
      stb_o        <= stb_d;
      cyc_o        <= stb_d;
      busy_o       <= busy_d;
      timeout_o    <= timeout_d;
    end
  end

endmodule
